// File: rtl/mem_lsu.sv
// Single-outstanding load/store unit: latches one request, runs one valid/ready bus transaction, then pulses done.
// Best-case latency is 3 cycles from acceptance to done. req_ready is low outside IDLE, and a misaligned access completes in 1 cycle.
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] ram_addr,
  input  logic [63:0] src2,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [63:0] bus_addr,
  output logic        bus_wen,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wmask,
  input  logic        bus_resp_valid,
  input  logic [63:0] bus_rdata,
  output logic        done_valid,
  output logic [63:0] done_rdata,
  output logic        done_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state, state_nxt;
  logic [63:0] addr_q;
  logic [63:0] src2_q;
  logic [63:0] rdata_q;
  logic        is_store_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        err_q;
  logic        misaligned;
  logic [63:0] load_sh;
  logic [63:0] load_ext;
  logic [7:0]  mask_base;

  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'd1:    misaligned = ram_addr[0];
      2'd2:    misaligned = |ram_addr[1:0];
      2'd3:    misaligned = |ram_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = misaligned ? DONE : REQ;
      REQ:  if (bus_req_ready) state_nxt = RESP;
      RESP: if (bus_resp_valid) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request and response latches
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      src2_q     <= '0;
      rdata_q    <= '0;
      is_store_q <= 1'b0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q     <= ram_addr;
        src2_q     <= src2;
        is_store_q <= is_store;
        size_q     <= size;
        uns_q      <= is_unsigned;
        err_q      <= misaligned;
        rdata_q    <= '0;
      end
      if (state == RESP && bus_resp_valid) rdata_q <= bus_rdata;
    end
  end

  always_comb begin
    load_sh  = rdata_q >> {addr_q[2:0], 3'b000};
    load_ext = load_sh;
    case (size_q)
      2'd0: load_ext = uns_q ? {56'd0, load_sh[7:0]}  : {{56{load_sh[7]}},  load_sh[7:0]};
      2'd1: load_ext = uns_q ? {48'd0, load_sh[15:0]} : {{48{load_sh[15]}}, load_sh[15:0]};
      2'd2: load_ext = uns_q ? {32'd0, load_sh[31:0]} : {{32{load_sh[31]}}, load_sh[31:0]};
      default: load_ext = load_sh;
    endcase
  end

  always_comb begin
    mask_base = 8'hFF;
    case (size_q)
      2'd0:    mask_base = 8'h01;
      2'd1:    mask_base = 8'h03;
      2'd2:    mask_base = 8'h0F;
      default: mask_base = 8'hFF;
    endcase
  end

  // Output decode: state plus latched registers only, never the bus inputs
  always_comb begin
    req_ready     = (state == IDLE);
    bus_req_valid = (state == REQ);
    bus_addr      = {addr_q[63:3], 3'b000};
    bus_wdata     = src2_q << {addr_q[2:0], 3'b000};
    bus_wen       = 1'b0;
    bus_wmask     = 8'h00;
    done_valid    = 1'b0;
    done_err      = 1'b0;
    done_rdata    = '0;
    if (state == REQ && is_store_q) begin
      bus_wen   = 1'b1;
      bus_wmask = mask_base << addr_q[2:0];
    end
    if (state == DONE) begin
      done_valid = 1'b1;
      done_err   = err_q;
      if (!is_store_q && !err_q) done_rdata = load_ext;
    end
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit between the execute stage and data memory. It latches one memory request formed from the execute-stage address (`ram_addr`) and store operand (`src2`), and drives a valid/ready memory bus with an 8-byte-aligned address, byte mask and shifted write data. It waits for the memory response, then hands a byte-aligned, sign- or zero-extended load result, or a store completion, to writeback. It holds one request at a time and back-pressures the core via `req_ready`.

## Interface
Parameters: none. Widths are fixed at XLEN = 64.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: core presents a memory request.
- `req_ready` out 1: unit can accept a request; high only in IDLE.
- `ram_addr` in 64: byte address from the execute stage.
- `src2` in 64: store data, taken from the low bytes.
- `is_store` in 1: 1 = store, 0 = load.
- `size` in 2: 0 = byte, 1 = half, 2 = word, 3 = double.
- `is_unsigned` in 1: loads only; zero-extend when 1, sign-extend when 0.
- `bus_req_valid` out 1: bus request valid.
- `bus_req_ready` in 1: memory accepts the request.
- `bus_addr` out 64: `{addr[63:3], 3'b000}`.
- `bus_wen` out 1: write request.
- `bus_wdata` out 64: store data shifted to its lane.
- `bus_wmask` out 8: byte enables; 0 for loads.
- `bus_resp_valid` in 1: memory response or write acknowledge.
- `bus_rdata` in 64: read data, full aligned doubleword.
- `done_valid` out 1: one-cycle completion pulse.
- `done_rdata` out 64: extended load result; 0 for stores and errors.
- `done_err` out 1: misaligned access; qualified by `done_valid`.

## Operation
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch `addr`, `src2`, `is_store`, `size` and `is_unsigned`.
  - Misaligned access goes to DONE with the error set. Otherwise go to REQ.
- Misaligned means `addr[size-1:0] != 0`: half at an odd address, word with `addr[1:0] != 0`, double with `addr[2:0] != 0`. A misaligned access issues no bus transaction.
- REQ:
  - `bus_req_valid` = 1.
  - `bus_addr`, `bus_wen`, `bus_wdata` and `bus_wmask` are stable, driven from the latched registers.
  - When `bus_req_ready` = 1, go to RESP.
- RESP:
  - Wait for `bus_resp_valid`; there is no timeout.
  - On `bus_resp_valid`, latch `bus_rdata` and go to DONE.
  - `bus_resp_valid` outside RESP is ignored.
- DONE:
  - `done_valid` = 1 for exactly one cycle, then go to IDLE.
  - No back-pressure from writeback.
- Store byte mask: `wmask = base << addr[2:0]`, with base = 0x01, 0x03, 0x0F or 0xFF by size.
- Store data: `wdata = src2 << (8*addr[2:0])`. Unused lanes are don't-care.
- Load: `sh = bus_rdata >> (8*addr[2:0])`. Take the low 8/16/32/64 bits, then sign- or zero-extend per `is_unsigned`. For size 3, `is_unsigned` is ignored.
- A store completes with `done_rdata` = 0 and `done_err` = 0.
- Requests arriving while `req_ready` = 0 are not latched; the core holds them.

## Timing
- Reset values:
  - state = IDLE.
  - `req_ready` = 1.
  - `bus_req_valid` = 0, `bus_wen` = 0, `bus_wmask` = 0, `bus_addr` = 0, `bus_wdata` = 0.
  - `done_valid` = 0, `done_rdata` = 0, `done_err` = 0.
  - Internal latches cleared.
- Cycle N: `req_valid` && `req_ready` accepted.
  - Aligned access: `bus_req_valid` is high from N+1.
  - Misaligned access: `done_valid` and `done_err` are high at N+1.
- Bus handshake completes at cycle M (the cycle with `bus_req_valid` && `bus_req_ready`). `bus_req_valid` drops at M+1.
- Response: `bus_resp_valid` at cycle K ≥ M+1 gives `done_valid` at K+1.
- Best case, with `bus_req_ready` at N+1 and response at N+2: `done_valid` at N+3, and the next request accepted at N+4.
- Request and response in the same cycle: a response in the handshake cycle M is not captured. The memory must respond at M+1 or later.
- Reset mid-operation in any state: on the next edge go to IDLE with all outputs at reset values. The outstanding bus transaction is abandoned and its later response ignored. No `done_valid` is produced for the dropped request.
- Outputs are registered or decoded from the state only; there is no combinational path from `bus_*` inputs to `bus_*` outputs.

## Test plan
- Aligned double load:
  - Stimulus: addr = 0x80000008, size = 3; memory returns `bus_rdata` = 0x1122334455667788 with `bus_req_ready` and the response one cycle apart.
  - Required: `bus_addr` = 0x80000008, `bus_wmask` = 0, `done_rdata` = 0x1122334455667788, `done_valid` 3 cycles after acceptance.
- Byte loads, signed and unsigned:
  - Stimulus: addr = 0x80000003, `bus_rdata` = 0x00000000_80FF0000.
  - Required: byte = 0x80; signed gives `done_rdata` = 0xFFFFFFFFFFFFFF80, unsigned gives 0x80.
- Half store:
  - Stimulus: addr = 0x80000006, `src2` = 0xABCD.
  - Required: `bus_addr` = 0x80000000, `bus_wmask` = 0xC0, `bus_wdata[63:48]` = 0xABCD, `bus_wen` = 1; `done_rdata` = 0 on completion.
- Misaligned word load:
  - Stimulus: addr = 0x80000002, size = 2.
  - Required: `bus_req_valid` never asserts; `done_valid` = `done_err` = 1 one cycle after acceptance; `req_ready` back high the cycle after.
- Back-pressure:
  - Stimulus: hold `bus_req_ready` = 0 for 5 cycles, then send the response 4 cycles after the handshake.
  - Required: `bus_req_valid` and `bus_addr` held stable throughout; `req_ready` = 0 throughout; a new `req_valid` in that window is not accepted.
- Reset mid-operation:
  - Stimulus: assert `rst` for one cycle while in RESP, then send a late `bus_resp_valid`.
  - Required: all outputs at reset values after the edge; the late response produces no `done_valid`; the next request completes normally.
